// File: rtl/demux1_2_stream.sv
// demux1_2_stream
//   Packet-level 1-to-2 stream demultiplexer. The destination is taken from
//   i_in_sel on the first beat of each packet and held until the beat with
//   i_in_last. Each output is fed from its own small FIFO, so a stalled
//   consumer never blocks the other lane.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_in_valid / o_in_ready   input handshake
//   i_in_data, i_in_sel       input payload and destination (first beat only)
//   i_in_last                 final beat of packet
//   o_outN_valid / i_outN_ready, o_outN_data, o_outN_last   output lanes N=0,1
//   o_busy                    multi-beat packet in progress
//   o_pkt_cnt0/1              packets fully pushed into FIFO0/FIFO1 (wrapping)
//
// FSM states
//   state    | meaning
//   S_IDLE   | between packets; next beat's i_in_sel picks the lane
//   S_ROUTE0 | mid-packet, beats go to lane 0
//   S_ROUTE1 | mid-packet, beats go to lane 1
module demux1_2_stream #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_sel,
  input  logic              i_in_last,
  output logic              o_out0_valid,
  input  logic              i_out0_ready,
  output logic [DATA_W-1:0] o_out0_data,
  output logic              o_out0_last,
  output logic              o_out1_valid,
  input  logic              i_out1_ready,
  output logic [DATA_W-1:0] o_out1_data,
  output logic              o_out1_last,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_pkt_cnt0,
  output logic [CNT_W-1:0]  o_pkt_cnt1
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROUTE0 = 2'd1;
  localparam logic [1:0] S_ROUTE1 = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  // Each entry is {data, last}.
  logic [DATA_W:0]   r_mem     [2][DEPTH];
  logic [PTR_W-1:0]  r_wptr    [2];
  logic [PTR_W-1:0]  r_rptr    [2];
  logic [PTR_W:0]    r_count   [2];
  logic [CNT_W-1:0]  r_pkt_cnt [2];

  logic       w_target;
  logic       w_push;
  logic [1:0] w_full;
  logic [1:0] w_push_n;
  logic [1:0] w_pop;

  always_comb begin
    w_target    = (r_state == S_IDLE) ? i_in_sel : (r_state == S_ROUTE1);
    w_full[0]   = (r_count[0] == L_FULL);
    w_full[1]   = (r_count[1] == L_FULL);
    // Readiness looks only at the target FIFO's occupancy, never at a
    // same-cycle pop, so there is no ready path from the output side.
    o_in_ready  = !w_full[w_target];
    w_push      = i_in_valid && o_in_ready;
    w_push_n[0] = w_push && !w_target;
    w_push_n[1] = w_push &&  w_target;
    w_pop[0]    = (r_count[0] != '0) && i_out0_ready;
    w_pop[1]    = (r_count[1] != '0) && i_out1_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_push) begin
      if (i_in_last)
        w_state_nxt = S_IDLE;
      else if (r_state == S_IDLE)
        w_state_nxt = i_in_sel ? S_ROUTE1 : S_ROUTE0;
    end
    // The unused encoding falls back to idle.
    if (r_state == 2'd3)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      for (int n = 0; n < 2; n++) begin
        r_wptr[n]    <= '0;
        r_rptr[n]    <= '0;
        r_count[n]   <= '0;
        r_pkt_cnt[n] <= '0;
        for (int d = 0; d < DEPTH; d++)
          r_mem[n][d] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int n = 0; n < 2; n++) begin
        if (w_push_n[n]) begin
          r_mem[n][r_wptr[n]] <= {i_in_data, i_in_last};
          r_wptr[n]           <= r_wptr[n] + PTR_W'(1);
          if (i_in_last)
            r_pkt_cnt[n] <= r_pkt_cnt[n] + CNT_W'(1);
        end
        if (w_pop[n])
          r_rptr[n] <= r_rptr[n] + PTR_W'(1);
        case ({w_push_n[n], w_pop[n]})
          2'b10:   r_count[n] <= r_count[n] + (PTR_W+1)'(1);
          2'b01:   r_count[n] <= r_count[n] - (PTR_W+1)'(1);
          default: r_count[n] <= r_count[n];
        endcase
      end
    end
  end

  assign o_out0_valid = (r_count[0] != '0);
  assign o_out0_data  = r_mem[0][r_rptr[0]][DATA_W:1];
  assign o_out0_last  = r_mem[0][r_rptr[0]][0];
  assign o_out1_valid = (r_count[1] != '0);
  assign o_out1_data  = r_mem[1][r_rptr[1]][DATA_W:1];
  assign o_out1_last  = r_mem[1][r_rptr[1]][0];
  assign o_busy       = (r_state != S_IDLE);
  assign o_pkt_cnt0   = r_pkt_cnt[0];
  assign o_pkt_cnt1   = r_pkt_cnt[1];

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed bench for demux1_2_stream (DATA_W=8, DEPTH=2, CNT_W=2).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_demux1_2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_sel, in_last;
  logic [7:0] in_data;
  logic       out0_valid, out0_ready, out0_last;
  logic [7:0] out0_data;
  logic       out1_valid, out1_ready, out1_last;
  logic [7:0] out1_data;
  logic       busy;
  logic [1:0] pkt_cnt0, pkt_cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux1_2_stream #(.DATA_W(8), .DEPTH(2), .CNT_W(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_sel     (in_sel),
    .i_in_last    (in_last),
    .o_out0_valid (out0_valid),
    .i_out0_ready (out0_ready),
    .o_out0_data  (out0_data),
    .o_out0_last  (out0_last),
    .o_out1_valid (out1_valid),
    .i_out1_ready (out1_ready),
    .o_out1_data  (out1_data),
    .o_out1_last  (out1_last),
    .o_busy       (busy),
    .o_pkt_cnt0   (pkt_cnt0),
    .o_pkt_cnt1   (pkt_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, return 1 ns after the edge.
  task automatic send(input logic [7:0] d, input logic s, input logic l);
    int cyc = 0;
    in_valid = 1'b1; in_data = d; in_sel = s; in_last = l;
    #1;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("accept_within_bound", 32'(cyc < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #3;
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data",  out0_data,  0);
    chk("rst_out0_last",  out0_last,  0);
    chk("rst_out1_data",  out1_data,  0);
    chk("rst_busy",       busy,       0);
    chk("rst_cnt0",       pkt_cnt0,   0);
    chk("rst_cnt1",       pkt_cnt1,   0);
    chk("rst_in_ready",   in_ready,   1);
    #4 rst_n = 1'b1;
    tick(); tick();

    // Single-beat routing
    send(8'h11, 1'b0, 1'b1);
    chk("sb_out0_valid", out0_valid, 1);
    chk("sb_out0_data",  out0_data,  8'h11);
    chk("sb_out0_last",  out0_last,  1);
    chk("sb_out1_idle",  out1_valid, 0);
    chk("sb_cnt0",       pkt_cnt0,   1);
    chk("sb_busy0",      busy,       0);
    send(8'h22, 1'b1, 1'b1);
    chk("sb_out1_valid", out1_valid, 1);
    chk("sb_out1_data",  out1_data,  8'h22);
    chk("sb_out0_drained", out0_valid, 0);
    chk("sb_cnt1",       pkt_cnt1,   1);
    chk("sb_busy1",      busy,       0);
    tick();
    chk("sb_out1_drained", out1_valid, 0);

    // Select locked for the whole packet
    send(8'hA0, 1'b1, 1'b0);
    chk("lk_busy_b1",  busy,       1);
    chk("lk_data_b1",  out1_data,  8'hA0);
    chk("lk_last_b1",  out1_last,  0);
    chk("lk_out0_b1",  out0_valid, 0);
    send(8'hA1, 1'b0, 1'b0);
    chk("lk_busy_b2",  busy,       1);
    chk("lk_data_b2",  out1_data,  8'hA1);
    chk("lk_last_b2",  out1_last,  0);
    chk("lk_out0_b2",  out0_valid, 0);
    send(8'hA2, 1'b0, 1'b1);
    chk("lk_busy_b3",  busy,       0);
    chk("lk_data_b3",  out1_data,  8'hA2);
    chk("lk_last_b3",  out1_last,  1);
    chk("lk_out0_b3",  out0_valid, 0);
    chk("lk_cnt1",     pkt_cnt1,   2);
    chk("lk_cnt0",     pkt_cnt0,   1);
    tick();
    chk("lk_out1_drained", out1_valid, 0);

    // Backpressure on lane 0, lane 1 keeps flowing
    out0_ready = 1'b0;
    send(8'h01, 1'b0, 1'b1);
    chk("bp_cnt0_a", pkt_cnt0, 2);
    send(8'h02, 1'b0, 1'b1);
    chk("bp_cnt0_b", pkt_cnt0, 3);
    chk("bp_head",   out0_data, 8'h01);
    in_valid = 1'b1; in_data = 8'h55; in_sel = 1'b1; in_last = 1'b1;
    #1;
    chk("ind_ready_out1", in_ready, 1);
    in_valid = 1'b0;
    send(8'h55, 1'b1, 1'b1);
    chk("ind_out1_valid", out1_valid, 1);
    chk("ind_out1_data",  out1_data,  8'h55);
    chk("ind_cnt1",       pkt_cnt1,   3);
    chk("ind_out0_held",  out0_data,  8'h01);
    chk("ind_out0_valid", out0_valid, 1);

    in_valid = 1'b1; in_data = 8'h03; in_sel = 1'b0; in_last = 1'b1;
    #1;
    chk("bp_full_ready", in_ready, 0);
    tick();
    chk("bp_no_push_cnt", pkt_cnt0,  3);
    chk("bp_stall_head",  out0_data, 8'h01);
    chk("ind_out1_gone",  out1_valid, 0);
    #1 out0_ready = 1'b1;
    #1;
    chk("bp_full_pop_ready", in_ready, 0);
    tick();
    chk("bp_drain_head2", out0_data, 8'h02);
    chk("bp_cnt_wait",    pkt_cnt0,  3);
    chk("bp_ready_again", in_ready,  1);
    tick();
    in_valid = 1'b0;
    chk("bp_third_data",  out0_data,  8'h03);
    chk("bp_third_last",  out0_last,  1);
    chk("bp_third_valid", out0_valid, 1);
    chk("bp_cnt_wrap",    pkt_cnt0,   0);
    tick();
    chk("bp_all_drained", out0_valid, 0);

    // Counter wrap at CNT_W=2, starting from 0
    send(8'h60, 1'b0, 1'b1); chk("wr_cnt_1", pkt_cnt0, 1); chk("wr_data_1", out0_data, 8'h60);
    send(8'h61, 1'b0, 1'b1); chk("wr_cnt_2", pkt_cnt0, 2); chk("wr_data_2", out0_data, 8'h61);
    send(8'h62, 1'b0, 1'b1); chk("wr_cnt_3", pkt_cnt0, 3); chk("wr_data_3", out0_data, 8'h62);
    send(8'h63, 1'b0, 1'b1); chk("wr_cnt_4", pkt_cnt0, 0); chk("wr_data_4", out0_data, 8'h63);
    send(8'h64, 1'b0, 1'b1); chk("wr_cnt_5", pkt_cnt0, 1); chk("wr_data_5", out0_data, 8'h64);
    tick();

    // Async reset in the middle of a lane-1 packet
    out1_ready = 1'b0;
    send(8'h77, 1'b1, 1'b0);
    chk("ar_pre_busy",  busy,       1);
    chk("ar_pre_out1",  out1_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_out1_valid", out1_valid, 0);
    chk("ar_out1_data",  out1_data,  0);
    chk("ar_busy",       busy,       0);
    chk("ar_cnt0",       pkt_cnt0,   0);
    chk("ar_cnt1",       pkt_cnt1,   0);
    #2 rst_n = 1'b1;
    out1_ready = 1'b1;
    tick();
    send(8'h88, 1'b0, 1'b1);
    chk("ar_next_out0",  out0_valid, 1);
    chk("ar_next_data",  out0_data,  8'h88);
    chk("ar_next_out1",  out1_valid, 0);
    chk("ar_next_cnt0",  pkt_cnt0,   1);
    chk("ar_next_busy",  busy,       0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
